// File: rtl/dds_sweep_ctrl.sv
// Purpose : frequency-sweep scheduler driving the DDS 32-bit cfg word {dds_on, dds_inv, phase_inc[29:0]}.
// Latency : a register write takes effect on the next clk edge; cfg/busy/sweep_done are registered.
// Backpressure: none; the host may write one register per cycle and writes are always accepted.
//
// Ports:
//   clk, rst            system clock (DDS domain), synchronous active-high reset
//   wr_en/wr_addr/wr_data  host write port: 0=START_INC 1=STOP_INC 2=STEP_INC 3=CTRL
//                       CTRL: bit0 go, bit1 inv, bit2 repeat, [16+DWELL_W-1:16] dwell
//   cfg                 {dds_on, inv, phase_inc[29:0]} to the DDS
//   busy                high while sweeping (RUN_UP / RUN_DN)
//   sweep_done          one-cycle pulse at the end of the stop-frequency dwell
// Optional feature: define DDS_SWEEP_BIDIR_EN for triangle sweeping (state RUN_DN).

module dds_sweep_ctrl #(
    parameter int DWELL_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic [1:0]  wr_addr,
    input  logic [31:0] wr_data,
    output logic [31:0] cfg,
    output logic        busy,
    output logic        sweep_done
);

    typedef enum logic [1:0] {IDLE, RUN_UP, HOLD, RUN_DN} state_t;

    state_t              state;

    // Host-visible shadow registers; only copied into the working set on go.
    logic [29:0]         start_h, stop_h, step_h;

    // Working set used by the running sweep.
    logic [29:0]         start_w, stop_w, step_w;
    logic                inv_w, rep_w;
    logic [DWELL_W-1:0]  reload_w;      // effective dwell minus one
    logic [DWELL_W-1:0]  cnt;
    logic [29:0]         cur_inc;
    logic                dds_on;

    logic                ctrl_wr;
    logic [DWELL_W-1:0]  dwell_in;
    logic [DWELL_W-1:0]  reload_in;
    logic [30:0]         up_sum;
    logic [29:0]         up_next;
    logic                unused_bits;

    assign ctrl_wr   = wr_en && (wr_addr == 2'd3);
    assign dwell_in  = wr_data[16 +: DWELL_W];
    // dwell=0 behaves as a one-clock dwell, so both 0 and 1 reload the counter with 0.
    assign reload_in = (dwell_in == '0) ? '0 : dwell_in - 1'b1;

    // Upward step in 31 bits so a wrap past 2^30 still clamps to stop.
    assign up_sum  = {1'b0, cur_inc} + {1'b0, step_w};
    assign up_next = (up_sum >= {1'b0, stop_w}) ? stop_w : up_sum[29:0];

`ifdef DDS_SWEEP_BIDIR_EN
    logic [29:0] dn_diff;
    logic [29:0] dn_next;

    // Downward step clamps at start; a step larger than cur_inc would underflow, so it clamps too.
    assign dn_diff = cur_inc - step_w;
    assign dn_next = ((step_w > cur_inc) || (dn_diff <= start_w)) ? start_w : dn_diff;
`endif

    // Increment bits [31:30] and unassigned CTRL bits carry no function.
    assign unused_bits = ^wr_data;

    assign cfg = {dds_on, inv_w, cur_inc};

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            start_h    <= '0;
            stop_h     <= '0;
            step_h     <= '0;
            start_w    <= '0;
            stop_w     <= '0;
            step_w     <= '0;
            inv_w      <= 1'b0;
            rep_w      <= 1'b0;
            reload_w   <= '0;
            cnt        <= '0;
            cur_inc    <= '0;
            dds_on     <= 1'b0;
            busy       <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            sweep_done <= 1'b0;

            if (wr_en) begin
                case (wr_addr)
                    2'd0:    start_h <= wr_data[29:0];
                    2'd1:    stop_h  <= wr_data[29:0];
                    2'd2:    step_h  <= wr_data[29:0];
                    default: ;
                endcase
            end

            if (ctrl_wr) begin
                if (wr_data[0]) begin
                    // go: (re)start from freshly latched values, whatever the current state.
                    start_w  <= start_h;
                    stop_w   <= stop_h;
                    step_w   <= step_h;
                    inv_w    <= wr_data[1];
                    rep_w    <= wr_data[2];
                    reload_w <= reload_in;
                    cnt      <= reload_in;
                    cur_inc  <= start_h;
                    state    <= RUN_UP;
                    dds_on   <= 1'b1;
                    busy     <= 1'b1;
                end else begin
                    // abort: silent return to IDLE, no completion pulse.
                    state  <= IDLE;
                    cnt    <= '0;
                    dds_on <= 1'b0;
                    busy   <= 1'b0;
                end
            end else begin
                case (state)
                    RUN_UP: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            cnt <= reload_w;
                            if (cur_inc >= stop_w) begin
                                sweep_done <= 1'b1;
                                if (!rep_w) begin
                                    state <= HOLD;
                                    busy  <= 1'b0;
                                end else begin
`ifdef DDS_SWEEP_BIDIR_EN
                                    state   <= RUN_DN;
                                    cur_inc <= dn_next;
`else
                                    cur_inc <= start_w;
`endif
                                end
                            end else begin
                                cur_inc <= up_next;
                            end
                        end
                    end
`ifdef DDS_SWEEP_BIDIR_EN
                    RUN_DN: begin
                        if (cnt != '0) begin
                            cnt <= cnt - 1'b1;
                        end else begin
                            cnt <= reload_w;
                            // End of the start dwell turns the sweep upward again.
                            if (cur_inc <= start_w) begin
                                state   <= RUN_UP;
                                cur_inc <= up_next;
                            end else begin
                                cur_inc <= dn_next;
                            end
                        end
                    end
`endif
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl: directed and random sweeps compared cycle by cycle against
// an expected-trace model built from the sweep rules.
module tb_dds_sweep_ctrl;

`ifdef DDS_SWEEP_BIDIR_EN
    localparam bit BIDIR = 1'b1;
`else
    localparam bit BIDIR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic [1:0]  wr_addr;
    logic [31:0] wr_data;
    logic [31:0] cfg;
    logic        busy;
    logic        sweep_done;

    int checks = 0;
    int errors = 0;

    logic [31:0] e_cfg[$];
    bit          e_busy[$];
    bit          e_done[$];
    int          idx;

    always #5 clk = ~clk;

    dds_sweep_ctrl #(.DWELL_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .cfg        (cfg),
        .busy       (busy),
        .sweep_done (sweep_done)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic int unsigned up_nx(input int unsigned v, stp, sp);
        return (v + stp >= sp) ? sp : v + stp;
    endfunction

    function automatic int unsigned dn_nx(input int unsigned v, stp, st);
        if (stp > v) return st;
        return (v - stp <= st) ? st : v - stp;
    endfunction

    // Expected per-cycle trace starting the cycle after the go write is applied.
    task automatic build(input int unsigned st, sp, stp, dw, input bit inv, rep, input int n);
        int unsigned v;
        int          d;
        bit          hold, dn, pend;
        logic [31:0] word;
        v = st; d = (dw == 0) ? 1 : int'(dw); hold = 0; dn = 0; pend = 0;
        e_cfg.delete(); e_busy.delete(); e_done.delete();
        idx = 0;
        while (e_cfg.size() < n) begin
            for (int i = 0; i < d && e_cfg.size() < n; i++) begin
                word = {1'b1, inv, v[29:0]};
                e_cfg.push_back(word);
                e_busy.push_back(!hold);
                e_done.push_back(pend && i == 0);
            end
            pend = 0;
            if (!hold) begin
                if (!dn) begin
                    if (v >= sp) begin
                        pend = 1;
                        if (!rep) hold = 1;
                        else if (BIDIR) begin dn = 1; v = dn_nx(v, stp, st); end
                        else v = st;
                    end else begin
                        v = up_nx(v, stp, sp);
                    end
                end else begin
                    if (v <= st) begin dn = 0; v = up_nx(v, stp, sp); end
                    else v = dn_nx(v, stp, st);
                end
            end
        end
    endtask

    task automatic drive(input bit we, input logic [1:0] a, input logic [31:0] d);
        wr_en = we; wr_addr = a; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic cmp_cycle();
        chk("cfg",  cfg,        e_cfg[idx]);
        chk("busy", busy,       e_busy[idx]);
        chk("done", sweep_done, e_done[idx]);
        idx++;
    endtask

    task automatic run(input int n);
        repeat (n) begin
            cmp_cycle();
            @(negedge clk);
        end
    endtask

    task automatic setup(input int unsigned st, sp, stp, dw, input bit inv, rep, input int n);
        drive(1'b1, 2'd0, st);
        drive(1'b1, 2'd1, sp);
        drive(1'b1, 2'd2, stp);
        drive(1'b1, 2'd3, {dw[15:0], 13'd0, rep, inv, 1'b1});
        build(st, sp, stp, dw, inv, rep, n);
    endtask

    task automatic abort_chk(input string tag);
        drive(1'b1, 2'd3, 32'h0);
        chk({tag, "_on"},   cfg[31],    1'b0);
        chk({tag, "_busy"}, busy,       1'b0);
        chk({tag, "_done"}, sweep_done, 1'b0);
    endtask

    initial begin
        int unsigned st, sp, stp, dw;
        bit inv, rep;
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        @(negedge clk);

        // Reset dominates concurrent writes.
        drive(1'b1, 2'd0, 32'd77);
        drive(1'b1, 2'd1, 32'd99);
        drive(1'b1, 2'd2, 32'd5);
        drive(1'b1, 2'd3, 32'h0003_0007);
        chk("rst_cfg",  cfg,        32'h0);
        chk("rst_busy", busy,       1'b0);
        chk("rst_done", sweep_done, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        chk("idle_cfg", cfg, 32'h0);

        // Go with untouched registers: start=stop=0, so one dwell then HOLD at 0.
        drive(1'b1, 2'd3, 32'h0001_0001);
        build(0, 0, 0, 1, 0, 0, 6);
        run(6);

        // Basic ramp with hold.
        setup(100, 130, 10, 3, 0, 0, 20);
        run(20);
        chk("hold_word", cfg, 32'h8000_0082);
        chk("hold_busy", busy, 1'b0);
        abort_chk("abort1");

        // dwell=0 acts as one clock; last step clamps to 125.
        setup(100, 125, 10, 0, 0, 0, 8);
        run(8);

        // Repeat with inversion: sawtooth or triangle depending on build.
        setup(0, 20, 10, 2, 1, 1, 30);
        run(30);
        abort_chk("abort2");

        // STOP rewrite mid-run has no effect; abort two cycles later.
        setup(100, 200, 10, 2, 0, 0, 40);
        run(5);
        cmp_cycle(); drive(1'b1, 2'd1, 32'd50);
        cmp_cycle(); drive(1'b0, 2'd0, 32'd0);
        cmp_cycle();
        abort_chk("abort3");

        // start > stop: single dwell at start, then HOLD.
        setup(200, 100, 5, 2, 0, 0, 10);
        run(10);

        // Restart from HOLD, then restart from RUN without abort.
        setup(10, 50, 10, 1, 0, 0, 6);
        run(3);
        setup(300, 310, 5, 1, 1, 0, 10);
        run(10);

        // Random sweeps.
        for (int it = 0; it < 12; it++) begin
            st  = $urandom_range(0, 200);
            sp  = $urandom_range(0, 200);
            stp = $urandom_range(0, 40);
            dw  = $urandom_range(0, 4);
            inv = 1'($urandom_range(0, 1));
            rep = 1'($urandom_range(0, 1));
            setup(st, sp, stp, dw, inv, rep, 40);
            run(40);
            if (it % 2 == 1) abort_chk("abort_rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
